// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the load scoreboard hazard unit.
package rv32i_pkg;
    localparam int              REG_ADDR_W = 5;
    localparam logic [4:0]      REG_X0     = 5'd0;
endpackage

// File: rtl/hazard_tag_fifo.sv
// In-order FIFO of outstanding load destination tags; every entry's tag and
// valid are exposed so the hazard logic can compare them all in parallel.
module hazard_tag_fifo
    import rv32i_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  push_req,
    input  logic [REG_ADDR_W-1:0]                 push_tag,
    input  logic                                  pop_req,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      tags,
    output logic [DEPTH-1:0]                      vlds,
    output logic [CNT_W-1:0]                      cnt,
    output logic                                  full,
    output logic                                  underflow
);
    logic [DEPTH-1:0][REG_ADDR_W-1:0] tag_q, tag_d;
    logic [DEPTH-1:0]                 vld_q, vld_d;
    logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             empty;
    logic                             push;
    logic                             pop;

    always_comb begin
        full  = (cnt_q == CNT_W'(DEPTH));
        empty = (cnt_q == '0);
        // A response arriving with an issue into an empty FIFO retires that
        // very load: nothing is stored and the count stays put.
        push      = push_req && (!full || pop_req) && !(pop_req && empty);
        pop       = pop_req && !empty;
        underflow = pop_req && empty && !push_req;

        tag_d    = tag_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Clear before set so a full push+pop on the shared slot keeps it valid.
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            tag_d[wr_ptr_q] = push_tag;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            tag_q    <= tag_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign tags = tag_q;
    assign vlds = vld_q;
    assign cnt  = cnt_q;
endmodule

// File: rtl/load_scoreboard_hazard_unit.sv
// Load-use hazard detector with an in-order scoreboard of outstanding loads.
// Define HAZARD_STALL_CNT_EN to add the saturating stall_cycles counter port.
module load_scoreboard_hazard_unit
    import rv32i_pkg::*;
#(
    parameter int MAX_PENDING = 4,
    parameter int STALL_CNT_W = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             id_valid,
    input  logic [REG_ADDR_W-1:0]            id_rs1,
    input  logic [REG_ADDR_W-1:0]            id_rs2,
    input  logic                             id_rs1_used,
    input  logic                             id_rs2_used,
    input  logic                             ex_load_valid,
    input  logic [REG_ADDR_W-1:0]            ex_rd,
    input  logic                             issue_valid,
    input  logic [REG_ADDR_W-1:0]            issue_rd,
    input  logic                             rsp_valid,
    output logic                             stall,
    output logic                             full,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending_cnt,
    output logic                             err_underflow
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]           stall_cycles
`endif
);
    logic [MAX_PENDING-1:0][REG_ADDR_W-1:0] tags;
    logic [MAX_PENDING-1:0]                 vlds;
    logic                                   underflow;
    logic                                   err_q, err_d;
    logic                                   rs1_hit, rs2_hit;

    generate
        if (MAX_PENDING < 2 || MAX_PENDING > 16 || (MAX_PENDING & (MAX_PENDING - 1)) != 0)
            $error("MAX_PENDING must be a power of two in 2..16");
        if (STALL_CNT_W < 1)
            $error("STALL_CNT_W must be at least 1");
    endgenerate

    hazard_tag_fifo #(.DEPTH(MAX_PENDING)) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_req  (issue_valid),
        .push_tag  (issue_rd),
        .pop_req   (rsp_valid),
        .tags      (tags),
        .vlds      (vlds),
        .cnt       (pending_cnt),
        .full      (full),
        .underflow (underflow)
    );

    // Entries popped this cycle still match: the pop only lands at the edge.
    function automatic logic reg_match(
        input logic [REG_ADDR_W-1:0]              r,
        input logic                               ld_v,
        input logic [REG_ADDR_W-1:0]              ld_rd,
        input logic [MAX_PENDING-1:0][REG_ADDR_W-1:0] t,
        input logic [MAX_PENDING-1:0]             v
    );
        logic hit;
        hit = ld_v && (ld_rd == r);
        for (int i = 0; i < MAX_PENDING; i++)
            if (v[i] && (t[i] == r)) hit = 1'b1;
        return (r != REG_X0) && hit;
    endfunction

    always_comb begin
        rs1_hit = id_rs1_used && reg_match(id_rs1, ex_load_valid, ex_rd, tags, vlds);
        rs2_hit = id_rs2_used && reg_match(id_rs2, ex_load_valid, ex_rd, tags, vlds);
        stall   = rst_n && ((id_valid && (rs1_hit || rs2_hit)) ||
                            (full && ex_load_valid && !rsp_valid));
        err_d   = err_q || underflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_underflow = err_q;

`ifdef HAZARD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cycles_q <= '0;
        else        stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_load_scoreboard_hazard_unit.sv
// Directed-vector bench for load_scoreboard_hazard_unit with hand-computed
// expectations; define HAZARD_STALL_CNT_EN to also exercise stall_cycles.
module tb_load_scoreboard_hazard_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2;
    logic       id_rs1_used, id_rs2_used;
    logic       ex_load_valid;
    logic [4:0] ex_rd;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       rsp_valid;
    logic       stall, full, err_underflow;
    logic [2:0] pending_cnt;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int vecs = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    load_scoreboard_hazard_unit #(.MAX_PENDING(4), .STALL_CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .ex_load_valid (ex_load_valid),
        .ex_rd         (ex_rd),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .rsp_valid     (rsp_valid),
        .stall         (stall),
        .full          (full),
        .pending_cnt   (pending_cnt),
        .err_underflow (err_underflow)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd0;
        id_rs1_used = 1'b1; id_rs2_used = 1'b0;
        ex_load_valid = 1'b1; ex_rd = 5'd5;
        issue_valid = 1'b0; issue_rd = 5'd0; rsp_valid = 1'b0;
        #12;
        chk("rst_pending", 32'(pending_cnt), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_stall_forced", 32'(stall), 0);
        chk("rst_err", 32'(err_underflow), 0);
        tick();
        rst_n = 1'b1;

        // load-use with the load still in EX
        #1 chk("ex_match_stall", 32'(stall), 1);
        id_rs1_used = 1'b0;
        #1 chk("ex_match_unused", 32'(stall), 0);

        // load to x0 never matches
        ex_rd = 5'd0; id_rs2 = 5'd0; id_rs2_used = 1'b1;
        #1 chk("x0_no_stall", 32'(stall), 0);
        ex_load_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd2;
        tick();
        issue_valid = 1'b0;
        chk("issue2_pending", 32'(pending_cnt), 1);
        id_rs2 = 5'd2;
        #1 chk("pending2_stall", 32'(stall), 1);
        id_rs2_used = 1'b0;

        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0;
        chk("x0_slot_pending", 32'(pending_cnt), 2);
        id_rs1 = 5'd0; id_rs1_used = 1'b1;
        #1 chk("x0_slot_no_stall", 32'(stall), 0);
        id_rs1_used = 1'b0;
        rsp_valid = 1'b1;
        tick(); tick();
        rsp_valid = 1'b0;
        chk("drain1_pending", 32'(pending_cnt), 0);

        // fill to capacity
        for (int r = 3; r <= 6; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r);
            tick();
        end
        chk("fill_pending", 32'(pending_cnt), 4);
        chk("fill_full", 32'(full), 1);
        issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        chk("full_drop_pending", 32'(pending_cnt), 4);
        id_rs1 = 5'd9; id_rs1_used = 1'b1;
        #1 chk("dropped_tag_no_stall", 32'(stall), 0);
        id_rs1 = 5'd3;
        #1 chk("head_tag_stall", 32'(stall), 1);
        id_rs1_used = 1'b0;
        ex_load_valid = 1'b1; ex_rd = 5'd0;
        #1 chk("full_ex_load_stall", 32'(stall), 1);
        rsp_valid = 1'b1;
        #1 chk("full_ex_load_rsp_nostall", 32'(stall), 0);
        ex_load_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd10;
        tick();
        issue_valid = 1'b0; rsp_valid = 1'b0;
        chk("full_pushpop_pending", 32'(pending_cnt), 4);
        chk("full_pushpop_full", 32'(full), 1);
        id_rs1 = 5'd3; id_rs1_used = 1'b1;
        #1 chk("head3_removed", 32'(stall), 0);
        id_rs1 = 5'd10;
        #1 chk("tag10_pushed", 32'(stall), 1);
        id_rs1 = 5'd4;
        #1 chk("tag4_kept", 32'(stall), 1);
        id_rs1_used = 1'b0;
        rsp_valid = 1'b1;
        repeat (4) tick();
        rsp_valid = 1'b0;
        chk("drain2_pending", 32'(pending_cnt), 0);
        chk("drain2_full", 32'(full), 0);

        // popped entry still matches in its response cycle
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("tag7_pending", 32'(pending_cnt), 1);
        id_rs1 = 5'd7; id_rs1_used = 1'b1;
        #1 chk("tag7_stall", 32'(stall), 1);
        rsp_valid = 1'b1;
        #1 chk("tag7_stall_rsp_cycle", 32'(stall), 1);
        tick();
        rsp_valid = 1'b0;
        #1 chk("tag7_stall_after", 32'(stall), 0);
        chk("tag7_pending_after", 32'(pending_cnt), 0);
        id_rs1_used = 1'b0;

        // underflow is sticky
        chk("err_before", 32'(err_underflow), 0);
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        chk("err_set", 32'(err_underflow), 1);
        chk("err_pending", 32'(pending_cnt), 0);
        tick(); tick();
        chk("err_held", 32'(err_underflow), 1);

        // reset mid-operation
        for (int r = 1; r <= 3; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r);
            tick();
        end
        issue_valid = 1'b0;
        chk("pre_rst_pending", 32'(pending_cnt), 3);
        id_rs1 = 5'd1; id_rs1_used = 1'b1;
        #1 chk("pre_rst_stall", 32'(stall), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pending", 32'(pending_cnt), 0);
        chk("mid_rst_stall", 32'(stall), 0);
        chk("mid_rst_err", 32'(err_underflow), 0);
        chk("mid_rst_full", 32'(full), 0);
        tick();
        rst_n = 1'b1;
        #1 chk("post_rst_no_stall", 32'(stall), 0);
        id_rs1_used = 1'b0;

`ifdef HAZARD_STALL_CNT_EN
        chk("stall_cnt_rst", stall_cycles, 0);
        ex_load_valid = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        repeat (10) tick();
        ex_load_valid = 1'b0; id_rs1_used = 1'b0;
        #1 chk("stall_cnt_10", stall_cycles, 10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule

// File: doc/load_scoreboard_hazard_unit.md
LOAD_SCOREBOARD_HAZARD_UNIT -- requirements
Module: load_scoreboard_hazard_unit

Interface
REQ-001 SHALL have parameter MAX_PENDING, default 4, meaning the maximum number of issued loads awaiting response (power of two, 2..16).
REQ-002 SHALL have parameter STALL_CNT_W, default 32, meaning the stall-cycle counter width.
REQ-003 SHALL have port clk  input  1  meaning the sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port id_valid  input  1  meaning a valid instruction is in IF/ID.
REQ-006 SHALL have ports id_rs1, id_rs2  input  5 each  meaning IF/ID source registers.
REQ-007 SHALL have ports id_rs1_used, id_rs2_used  input  1 each  meaning the source is actually read.
REQ-008 SHALL have ports ex_load_valid (input, 1) and ex_rd (input, 5), meaning a load in ID/EX and its destination register.
REQ-009 SHALL have ports issue_valid (input, 1) and issue_rd (input, 5), meaning the load leaves EX toward memory this cycle.
REQ-010 SHALL have port rsp_valid  input  1  meaning the oldest outstanding load writes back this cycle.
REQ-011 SHALL have port stall  output  1  meaning hold PC and IF/ID and insert a bubble into ID/EX.
REQ-012 SHALL have port full  output  1  meaning pending count equals MAX_PENDING.
REQ-013 SHALL have port pending_cnt  output  $clog2(MAX_PENDING+1)  meaning the number of outstanding loads.
REQ-014 SHALL have port err_underflow  output  1  meaning a sticky flag for rsp_valid received while empty.

Function
REQ-015 SHALL hold outstanding load destinations in an in-order tag FIFO: push on issue_valid, pop on rsp_valid.
REQ-016 SHALL define match(r) = (r != 0) and ((ex_load_valid and ex_rd == r) or any valid FIFO entry tag == r).
REQ-017 SHALL drive stall combinationally = id_valid and ((id_rs1_used and match(id_rs1)) or (id_rs2_used and match(id_rs2))), or (full and ex_load_valid and not rsp_valid).
REQ-018 SHALL have a FIFO pop take effect at the next edge, so an entry popped in cycle N still matches in cycle N; no same-cycle bypass.
REQ-019 SHALL, on simultaneous issue_valid and rsp_valid, push and pop in the same edge, leaving pending_cnt unchanged, including when full.
REQ-020 SHALL ignore issue_valid when full and rsp_valid is low; pending_cnt is unchanged.
REQ-021 SHALL, on rsp_valid while empty and without issue_valid, leave state unchanged and set err_underflow until reset.
REQ-022 SHALL, for a load to x0, occupy a FIFO slot while never matching any source.
REQ-023 SHALL wrap read and write pointers modulo MAX_PENDING.
REQ-024 SHALL update pending_cnt and full one cycle after the causing event.

Reset
REQ-025 SHALL, while rst_n is low, clear pointers, pending_cnt, entry valids, err_underflow and stall_cycles to 0, with stall forced to 0.
REQ-026 SHALL discard any transaction in flight when reset is asserted mid-operation, with no response owed.

Configuration
REQ-027 SHALL, with HAZARD_STALL_CNT_EN defined, add output stall_cycles  STALL_CNT_W  counting cycles with stall high, saturating at all-ones.
REQ-028 SHALL, without HAZARD_STALL_CNT_EN, have no stall_cycles port and no counter logic, with all other behaviour identical.

Structure
REQ-029 SHALL place REG_ADDR_W = 5 and REG_X0 = 5'd0 in the shared rv32i package.
REQ-030 SHALL implement the tag storage as sub-module hazard_tag_fifo, exposing per-entry tags and valids for parallel compare.

Verification
REQ-031 SHALL cover: ex_load_valid=1, ex_rd=5, id_rs1=5, rs1_used=1 -> stall=1 in the same cycle; with rs1_used=0 -> stall=0.
REQ-032 SHALL cover: load to x0 in EX, id_rs2=0 used -> stall=0; issue 2 -> pending_cnt=1 next cycle.
REQ-033 SHALL cover: issue rd=3,4,5,6 -> full=1; a further issue without rsp -> pending_cnt stays 4; issue+rsp together -> remains 4, head tag 3 removed.
REQ-034 SHALL cover: pending tag 7, id_rs1=7 -> stall=1 through the rsp cycle; stall=0 the cycle after.
REQ-035 SHALL cover: rsp_valid with pending_cnt=0 -> err_underflow=1, held until rst_n low.
REQ-036 SHALL cover: rst_n low mid-operation with pending_cnt=3 -> pending_cnt=0, stall=0 immediately; with HAZARD_STALL_CNT_EN, 10 stall cycles -> stall_cycles=10.
